// File: rtl/burst_increment_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : burst_increment_reader_pkg
// Description : Shared types and default widths for the burst increment
//               reader and its address-step helper.
//               Contents: state_e (IDLE/RUN/DONE), default ADDR_W / LEN_W.
// Revision    : 1.0 - initial release
// ============================================================================
package burst_increment_reader_pkg;

  localparam int c_ADDR_W_DEFAULT = 16;
  localparam int c_LEN_W_DEFAULT  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : burst_increment_reader_pkg
`default_nettype wire

// File: rtl/burst_increment_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : burst_increment_reader_if
// Description : Waveform-RAM read-address channel (valid/ready).
//               Rd_Addr  : read address, driven by master
//               Rd_Valid : Rd_Addr valid, driven by master
//               Rd_Ready : memory accepts Rd_Addr, driven by slave
// Revision    : 1.0 - initial release
// ============================================================================
interface burst_increment_reader_if #(
  parameter int ADDR_W = 16
);

  logic [ADDR_W-1:0] Rd_Addr;
  logic              Rd_Valid;
  logic              Rd_Ready;

  modport master (
    output Rd_Addr,
    output Rd_Valid,
    input  Rd_Ready
  );

  modport slave (
    input  Rd_Addr,
    input  Rd_Valid,
    output Rd_Ready
  );

endinterface : burst_increment_reader_if
`default_nettype wire

// File: rtl/burst_increment_reader_addr_wrap_step.sv
`default_nettype none
// ============================================================================
// Module      : burst_addr_wrap_step
// Description : Combinational next-address unit for table readers.
//               Next = Cur + Step, wrapped back into [0, Wrap] when the sum
//               passes Wrap. Step must not exceed Wrap+1.
//               Cur_Addr_i, Step_i, Wrap_Addr_i -> Next_Addr_o
// Revision    : 1.0 - initial release
// ============================================================================
module burst_addr_wrap_step #(
  parameter int ADDR_W = 16
) (
  input  wire logic [ADDR_W-1:0] Cur_Addr_i,
  input  wire logic [ADDR_W-1:0] Step_i,
  input  wire logic [ADDR_W-1:0] Wrap_Addr_i,
  output logic      [ADDR_W-1:0] Next_Addr_o
);

  localparam logic [ADDR_W-1:0] c_ONE = ADDR_W'(1);

  // Sum carries one extra bit so a carry out of the table top is visible.
  logic [ADDR_W:0] w_sum;

  assign w_sum = {1'b0, Cur_Addr_i} + {1'b0, Step_i};

  // The wrapped result always fits in ADDR_W bits, so the subtraction of
  // (Wrap+1) can be done modulo 2^ADDR_W on the low bits only.
  assign Next_Addr_o = (w_sum > {1'b0, Wrap_Addr_i})
                     ? (w_sum[ADDR_W-1:0] - Wrap_Addr_i - c_ONE)
                     : w_sum[ADDR_W-1:0];

endmodule : burst_addr_wrap_step
`default_nettype wire

// File: rtl/burst_increment_reader.sv
`default_nettype none
// ============================================================================
// Module      : burst_increment_reader
// Description : Issues an incrementing, wrapping burst of waveform-RAM read
//               addresses over a valid/ready channel.
//   Clock, Reset (sync, active-low)
//   Start_Addr, Burst_Len, Step, Wrap_Addr : operands, latched on accepted Go
//   Go     : start request (acted on in IDLE only)
//   Abort  : terminate a running burst, no Done
//   Loop   : restart at Start_Addr on the final beat (BURST_LOOP_EN only)
//   Rd     : read-address channel (master side)
//   Busy   : high in RUN
//   Done   : one-cycle completion / pass-boundary pulse
//   Count  : beats transferred in the current burst/pass
// Optional feature macro: BURST_LOOP_EN
// Revision    : 1.0 - initial release
// ============================================================================
module burst_increment_reader
  import burst_increment_reader_pkg::*;
#(
  parameter int ADDR_W = c_ADDR_W_DEFAULT,
  parameter int LEN_W  = c_LEN_W_DEFAULT
) (
  input  wire logic              Clock,
  input  wire logic              Reset,
  input  wire logic [ADDR_W-1:0] Start_Addr,
  input  wire logic [LEN_W-1:0]  Burst_Len,
  input  wire logic [ADDR_W-1:0] Step,
  input  wire logic [ADDR_W-1:0] Wrap_Addr,
  input  wire logic              Go,
  input  wire logic              Abort,
`ifdef BURST_LOOP_EN
  input  wire logic              Loop,
`endif
  burst_increment_reader_if.master Rd,
  output logic                   Busy,
  output logic                   Done,
  output logic [LEN_W-1:0]       Count
);

  localparam logic [LEN_W-1:0] c_LEN_ONE = LEN_W'(1);

  state_e            state_q,    state_d;
  logic [ADDR_W-1:0] rd_addr_q,  rd_addr_d;
  logic              rd_valid_q, rd_valid_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;
  logic [LEN_W-1:0]  count_q,    count_d;
  logic [LEN_W-1:0]  len_q,      len_d;
  logic [ADDR_W-1:0] step_q,     step_d;
  logic [ADDR_W-1:0] wrap_q,     wrap_d;
`ifdef BURST_LOOP_EN
  logic [ADDR_W-1:0] start_q,    start_d;
`endif

  logic              w_beat;
  logic              w_last;
  logic [ADDR_W-1:0] w_next_addr;

  assign w_beat = rd_valid_q & Rd.Rd_Ready;
  assign w_last = (count_q == (len_q - c_LEN_ONE));

  burst_addr_wrap_step #(
    .ADDR_W (ADDR_W)
  ) u_addr_step (
    .Cur_Addr_i  (rd_addr_q),
    .Step_i      (step_q),
    .Wrap_Addr_i (wrap_q),
    .Next_Addr_o (w_next_addr)
  );

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q    <= IDLE;
      rd_addr_q  <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= '0;
      len_q      <= '0;
      step_q     <= '0;
      wrap_q     <= '0;
`ifdef BURST_LOOP_EN
      start_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      count_q    <= count_d;
      len_q      <= len_d;
      step_q     <= step_d;
      wrap_q     <= wrap_d;
`ifdef BURST_LOOP_EN
      start_q    <= start_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    rd_valid_d = rd_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    count_d    = count_q;
    len_d      = len_q;
    step_d     = step_q;
    wrap_d     = wrap_q;
`ifdef BURST_LOOP_EN
    start_d    = start_q;
`endif

    case (state_q)
      IDLE: begin
        if (Go) begin
          len_d   = Burst_Len;
          step_d  = Step;
          wrap_d  = Wrap_Addr;
`ifdef BURST_LOOP_EN
          start_d = Start_Addr;
`endif
          count_d = '0;
          if (Burst_Len != '0) begin
            state_d    = RUN;
            rd_addr_d  = Start_Addr;
            rd_valid_d = 1'b1;
            busy_d     = 1'b1;
          end else begin
            // Zero-length burst completes without issuing any address.
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end

      RUN: begin
        if (w_beat) begin
          count_d   = count_q + c_LEN_ONE;
          rd_addr_d = w_next_addr;
        end
        // Abort has priority over the final-beat transition but a
        // coincident beat still counts.
        if (Abort) begin
          state_d    = IDLE;
          rd_valid_d = 1'b0;
          busy_d     = 1'b0;
        end else if (w_beat && w_last) begin
`ifdef BURST_LOOP_EN
          if (Loop) begin
            rd_addr_d = start_q;
            count_d   = '0;
            done_d    = 1'b1;
          end else
`endif
          begin
            state_d    = DONE;
            rd_valid_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d    = IDLE;
        rd_valid_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  assign Rd.Rd_Addr  = rd_addr_q;
  assign Rd.Rd_Valid = rd_valid_q;
  assign Busy        = busy_q;
  assign Done        = done_q;
  assign Count       = count_q;

endmodule : burst_increment_reader
`default_nettype wire

// File: tb/tb_burst_increment_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_burst_increment_reader
// Description : Directed self-checking bench for burst_increment_reader.
//               Inputs change and outputs are sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_burst_increment_reader;

  logic        Clock;
  logic        Reset;
  logic [15:0] Start_Addr;
  logic [15:0] Burst_Len;
  logic [15:0] Step;
  logic [15:0] Wrap_Addr;
  logic        Go;
  logic        Abort;
`ifdef BURST_LOOP_EN
  logic        Loop;
`endif
  logic        Busy;
  logic        Done;
  logic [15:0] Count;

  int checks = 0;
  int errors = 0;

  burst_increment_reader_if #(.ADDR_W(16)) rd_if ();

  burst_increment_reader #(
    .ADDR_W (16),
    .LEN_W  (16)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Start_Addr (Start_Addr),
    .Burst_Len  (Burst_Len),
    .Step       (Step),
    .Wrap_Addr  (Wrap_Addr),
    .Go         (Go),
    .Abort      (Abort),
`ifdef BURST_LOOP_EN
    .Loop       (Loop),
`endif
    .Rd         (rd_if),
    .Busy       (Busy),
    .Done       (Done),
    .Count      (Count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Accept a burst: operands presented with Go for one cycle, then
  // scrambled so only the latched copies can produce correct results.
  // Returns at the falling edge after the accepting rising edge.
  task automatic start_burst(input logic [15:0] s, input logic [15:0] l,
                             input logic [15:0] st, input logic [15:0] w);
    @(negedge Clock);
    Start_Addr = s; Burst_Len = l; Step = st; Wrap_Addr = w; Go = 1'b1;
    @(negedge Clock);
    Go = 1'b0;
    Start_Addr = 16'hDEAD; Burst_Len = 16'h0000; Step = 16'h0007; Wrap_Addr = 16'h0003;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge Clock);
    checks++;
    if (rd_if.Rd_Addr !== 16'h0 || rd_if.Rd_Valid !== 1'b0 || Busy !== 1'b0 ||
        Done !== 1'b0 || Count !== 16'h0) begin
      errors++;
      $display("FAIL reset: addr=%h valid=%b busy=%b done=%b count=%0d, required all zero",
               rd_if.Rd_Addr, rd_if.Rd_Valid, Busy, Done, Count);
    end
    Reset = 1'b1;
  endtask

  task automatic test_basic();
    logic [15:0] exp_a [4] = '{16'h0010, 16'h0011, 16'h0012, 16'h0013};
    rd_if.Rd_Ready = 1'b1;
    start_burst(16'h0010, 16'd4, 16'd1, 16'hFFFF);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_if.Rd_Valid !== 1'b1 || rd_if.Rd_Addr !== exp_a[i] || Busy !== 1'b1 ||
          Count !== 16'(i) || Done !== 1'b0) begin
        errors++;
        $display("FAIL basic_beat%0d: addr=%h valid=%b busy=%b done=%b count=%0d, required addr=%h valid=1 busy=1 done=0 count=%0d",
                 i, rd_if.Rd_Addr, rd_if.Rd_Valid, Busy, Done, Count, exp_a[i], i);
      end
      @(negedge Clock);
    end
    checks++;
    if (Done !== 1'b1 || rd_if.Rd_Valid !== 1'b0 || Busy !== 1'b0 || Count !== 16'd4) begin
      errors++;
      $display("FAIL basic_done: done=%b valid=%b busy=%b count=%0d, required done=1 valid=0 busy=0 count=4",
               Done, rd_if.Rd_Valid, Busy, Count);
    end
    @(negedge Clock);
    checks++;
    if (Done !== 1'b0 || Count !== 16'd4 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: done=%b busy=%b count=%0d, required done=0 busy=0 count=4",
               Done, Busy, Count);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] c_start [5] = '{16'h00FE, 16'h00FD, 16'h0005, 16'h0007, 16'hFFFE};
    logic [15:0] c_step  [5] = '{16'h0001, 16'h0003, 16'h0100, 16'h0000, 16'h0001};
    logic [15:0] c_wrap  [5] = '{16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 16'hFFFF};
    logic [15:0] exp_a [5][4] = '{
      '{16'h00FE, 16'h00FF, 16'h0000, 16'h0001},
      '{16'h00FD, 16'h0000, 16'h0003, 16'h0006},
      '{16'h0005, 16'h0005, 16'h0005, 16'h0005},
      '{16'h0007, 16'h0007, 16'h0007, 16'h0007},
      '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001}};
    rd_if.Rd_Ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      start_burst(c_start[c], 16'd4, c_step[c], c_wrap[c]);
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rd_if.Rd_Valid !== 1'b1 || rd_if.Rd_Addr !== exp_a[c][i]) begin
          errors++;
          $display("FAIL wrap_case%0d_beat%0d: addr=%h valid=%b, required addr=%h valid=1",
                   c, i, rd_if.Rd_Addr, rd_if.Rd_Valid, exp_a[c][i]);
        end
        @(negedge Clock);
      end
      checks++;
      if (Done !== 1'b1 || Count !== 16'd4) begin
        errors++;
        $display("FAIL wrap_case%0d_done: done=%b count=%0d, required done=1 count=4", c, Done, Count);
      end
      @(negedge Clock);
    end
  endtask

  task automatic test_backpressure();
    rd_if.Rd_Ready = 1'b1;
    start_burst(16'h0010, 16'd3, 16'd1, 16'hFFFF);
    checks++;
    if (rd_if.Rd_Addr !== 16'h0010 || rd_if.Rd_Valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_first: addr=%h valid=%b, required addr=0010 valid=1", rd_if.Rd_Addr, rd_if.Rd_Valid);
    end
    @(negedge Clock);
    rd_if.Rd_Ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_if.Rd_Addr !== 16'h0011 || rd_if.Rd_Valid !== 1'b1 || Count !== 16'd1 || Done !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: addr=%h valid=%b count=%0d done=%b, required addr=0011 valid=1 count=1 done=0",
                 i, rd_if.Rd_Addr, rd_if.Rd_Valid, Count, Done);
      end
      if (i < 2) @(negedge Clock);
    end
    rd_if.Rd_Ready = 1'b1;
    @(negedge Clock);
    checks++;
    if (rd_if.Rd_Addr !== 16'h0012 || rd_if.Rd_Valid !== 1'b1 || Count !== 16'd2) begin
      errors++;
      $display("FAIL bp_resume: addr=%h valid=%b count=%0d, required addr=0012 valid=1 count=2",
               rd_if.Rd_Addr, rd_if.Rd_Valid, Count);
    end
    @(negedge Clock);
    checks++;
    if (Done !== 1'b1 || rd_if.Rd_Valid !== 1'b0 || Count !== 16'd3) begin
      errors++;
      $display("FAIL bp_done: done=%b valid=%b count=%0d, required done=1 valid=0 count=3",
               Done, rd_if.Rd_Valid, Count);
    end
    @(negedge Clock);
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_single_done: done=%b busy=%b, required done=0 busy=0", Done, Busy);
    end
  endtask

  task automatic test_len_zero();
    rd_if.Rd_Ready = 1'b1;
    start_burst(16'h0030, 16'd0, 16'd1, 16'hFFFF);
    checks++;
    if (Done !== 1'b1 || rd_if.Rd_Valid !== 1'b0 || Busy !== 1'b0 || Count !== 16'd0) begin
      errors++;
      $display("FAIL len0_done: done=%b valid=%b busy=%b count=%0d, required done=1 valid=0 busy=0 count=0",
               Done, rd_if.Rd_Valid, Busy, Count);
    end
    @(negedge Clock);
    checks++;
    if (Done !== 1'b0 || rd_if.Rd_Valid !== 1'b0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL len0_idle: done=%b valid=%b busy=%b, required all 0", Done, rd_if.Rd_Valid, Busy);
    end
  endtask

  task automatic test_go_ignored();
    rd_if.Rd_Ready = 1'b0;
    start_burst(16'h0040, 16'd2, 16'd1, 16'hFFFF);
    Go = 1'b1; Start_Addr = 16'h0099; Burst_Len = 16'd5;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clock);
      checks++;
      if (rd_if.Rd_Addr !== 16'h0040 || rd_if.Rd_Valid !== 1'b1 || Count !== 16'd0) begin
        errors++;
        $display("FAIL go_run_ignored%0d: addr=%h valid=%b count=%0d, required addr=0040 valid=1 count=0",
                 i, rd_if.Rd_Addr, rd_if.Rd_Valid, Count);
      end
    end
    Go = 1'b0;
    rd_if.Rd_Ready = 1'b1;
    @(negedge Clock);
    checks++;
    if (rd_if.Rd_Addr !== 16'h0041 || Count !== 16'd1) begin
      errors++;
      $display("FAIL go_run_beat: addr=%h count=%0d, required addr=0041 count=1", rd_if.Rd_Addr, Count);
    end
    @(negedge Clock);
    checks++;
    if (Done !== 1'b1 || Count !== 16'd2) begin
      errors++;
      $display("FAIL go_run_done: done=%b count=%0d, required done=1 count=2", Done, Count);
    end
    repeat (2) @(negedge Clock);
    checks++;
    if (rd_if.Rd_Valid !== 1'b0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL go_not_queued: valid=%b busy=%b, required valid=0 busy=0", rd_if.Rd_Valid, Busy);
    end
  endtask

  task automatic test_go_held();
    rd_if.Rd_Ready = 1'b1;
    @(negedge Clock);
    Start_Addr = 16'h0050; Burst_Len = 16'd1; Step = 16'd1; Wrap_Addr = 16'hFFFF; Go = 1'b1;
    @(negedge Clock);
    checks++;
    if (rd_if.Rd_Addr !== 16'h0050 || rd_if.Rd_Valid !== 1'b1 || Count !== 16'd0) begin
      errors++;
      $display("FAIL held_first: addr=%h valid=%b count=%0d, required addr=0050 valid=1 count=0",
               rd_if.Rd_Addr, rd_if.Rd_Valid, Count);
    end
    Start_Addr = 16'h0060;
    @(negedge Clock);
    checks++;
    if (Done !== 1'b1 || rd_if.Rd_Valid !== 1'b0 || Count !== 16'd1) begin
      errors++;
      $display("FAIL held_done: done=%b valid=%b count=%0d, required done=1 valid=0 count=1",
               Done, rd_if.Rd_Valid, Count);
    end
    @(negedge Clock);
    checks++;
    if (Done !== 1'b0 || rd_if.Rd_Valid !== 1'b0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL held_idle: done=%b valid=%b busy=%b, required all 0", Done, rd_if.Rd_Valid, Busy);
    end
    @(negedge Clock);
    Go = 1'b0;
    checks++;
    if (rd_if.Rd_Addr !== 16'h0060 || rd_if.Rd_Valid !== 1'b1 || Busy !== 1'b1 || Count !== 16'd0) begin
      errors++;
      $display("FAIL held_restart: addr=%h valid=%b busy=%b count=%0d, required addr=0060 valid=1 busy=1 count=0",
               rd_if.Rd_Addr, rd_if.Rd_Valid, Busy, Count);
    end
    repeat (2) @(negedge Clock);
  endtask

  task automatic test_abort();
    rd_if.Rd_Ready = 1'b1;
    start_burst(16'h0000, 16'd8, 16'd1, 16'hFFFF);
    @(negedge Clock);
    Abort = 1'b1;
    @(negedge Clock);
    Abort = 1'b0;
    checks++;
    if (Count !== 16'd2 || rd_if.Rd_Valid !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) begin
      errors++;
      $display("FAIL abort: count=%0d valid=%b busy=%b done=%b, required count=2 valid=0 busy=0 done=0",
               Count, rd_if.Rd_Valid, Busy, Done);
    end
    @(negedge Clock);
    checks++;
    if (Done !== 1'b0 || rd_if.Rd_Valid !== 1'b0 || Count !== 16'd2) begin
      errors++;
      $display("FAIL abort_no_done: done=%b valid=%b count=%0d, required done=0 valid=0 count=2",
               Done, rd_if.Rd_Valid, Count);
    end
    // Abort while IDLE must not block an accepted Go.
    Abort = 1'b1; Go = 1'b1;
    Start_Addr = 16'h0070; Burst_Len = 16'd2; Step = 16'd1; Wrap_Addr = 16'hFFFF;
    @(negedge Clock);
    Abort = 1'b0; Go = 1'b0;
    checks++;
    if (rd_if.Rd_Addr !== 16'h0070 || rd_if.Rd_Valid !== 1'b1 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle_ignored: addr=%h valid=%b busy=%b, required addr=0070 valid=1 busy=1",
               rd_if.Rd_Addr, rd_if.Rd_Valid, Busy);
    end
    repeat (3) @(negedge Clock);
  endtask

  task automatic test_reset_mid();
    rd_if.Rd_Ready = 1'b1;
    start_burst(16'h0080, 16'd8, 16'd1, 16'hFFFF);
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    checks++;
    if (rd_if.Rd_Addr !== 16'h0 || rd_if.Rd_Valid !== 1'b0 || Busy !== 1'b0 ||
        Done !== 1'b0 || Count !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid: addr=%h valid=%b busy=%b done=%b count=%0d, required all zero",
               rd_if.Rd_Addr, rd_if.Rd_Valid, Busy, Done, Count);
    end
    Reset = 1'b1;
    @(negedge Clock);
    checks++;
    if (rd_if.Rd_Valid !== 1'b0 || Done !== 1'b0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after: valid=%b done=%b busy=%b, required all 0", rd_if.Rd_Valid, Done, Busy);
    end
  endtask

`ifdef BURST_LOOP_EN
  task automatic test_loop();
    logic [15:0] exp_a [4] = '{16'h0020, 16'h0021, 16'h0020, 16'h0021};
    logic        exp_d [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] exp_c [4] = '{16'd0, 16'd1, 16'd0, 16'd1};
    rd_if.Rd_Ready = 1'b1;
    Loop = 1'b1;
    start_burst(16'h0020, 16'd2, 16'd1, 16'hFFFF);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_if.Rd_Addr !== exp_a[i] || rd_if.Rd_Valid !== 1'b1 || Done !== exp_d[i] || Count !== exp_c[i]) begin
        errors++;
        $display("FAIL loop_beat%0d: addr=%h valid=%b done=%b count=%0d, required addr=%h valid=1 done=%b count=%0d",
                 i, rd_if.Rd_Addr, rd_if.Rd_Valid, Done, Count, exp_a[i], exp_d[i], exp_c[i]);
      end
      if (i == 3) Loop = 1'b0;
      @(negedge Clock);
    end
    checks++;
    if (Done !== 1'b1 || rd_if.Rd_Valid !== 1'b0 || Busy !== 1'b0 || Count !== 16'd2) begin
      errors++;
      $display("FAIL loop_end: done=%b valid=%b busy=%b count=%0d, required done=1 valid=0 busy=0 count=2",
               Done, rd_if.Rd_Valid, Busy, Count);
    end
    @(negedge Clock);
  endtask
`endif

  initial begin
    Reset = 1'b0; Start_Addr = '0; Burst_Len = '0; Step = '0; Wrap_Addr = '0;
    Go = 1'b0; Abort = 1'b0; rd_if.Rd_Ready = 1'b0;
`ifdef BURST_LOOP_EN
    Loop = 1'b0;
`endif
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_len_zero();
    test_go_ignored();
    test_go_held();
    test_abort();
    test_reset_mid();
`ifdef BURST_LOOP_EN
    test_loop();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule : tb_burst_increment_reader
`default_nettype wire
